// File: rtl/cs_wcs_seq_if.sv
// Control-store sequencer bus: request/abort from the host side, word
// strobes and data toward the control store, readback and status back.
interface cs_wcs_seq_if;
   logic        START;
   logic        DIR;
   logic        ABORT;
   logic [63:0] MI_IN;
   logic [15:0] CS_DATA_IN;
   logic [15:0] CS_DATA_OUT;
   logic [63:0] MI_OUT;
   logic [1:0]  RF_1_0;
   logic        LCS_n;
   logic        WCS_n;
   logic        RWCS_n;
   logic        BUSY;
   logic        DONE;

   modport master (
      output START, DIR, ABORT, MI_IN, CS_DATA_IN,
      input  CS_DATA_OUT, MI_OUT, RF_1_0, LCS_n, WCS_n, RWCS_n, BUSY, DONE
   );

   modport slave (
      input  START, DIR, ABORT, MI_IN, CS_DATA_IN,
      output CS_DATA_OUT, MI_OUT, RF_1_0, LCS_n, WCS_n, RWCS_n, BUSY, DONE
   );
endinterface

// File: rtl/cs_wcs_seq.sv
// Writable-control-store sequencer: moves a 64-bit microinstruction to or
// from the store as four 16-bit words with SETUP/STROBE/HOLD timing.
module cs_wcs_seq #(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2
) (
   input  logic         sysclk,
   input  logic         sys_rst_n,
   cs_wcs_seq_if.slave  bus
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_FIN} state_t;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  word_q, word_d;
   logic [63:0] mi_q, mi_d;
   logic        dir_q, dir_d;
   logic [63:0] mi_out_q, mi_out_d;
   logic [15:0] cs_data_out_q, cs_data_out_d;
   logic [1:0]  rf_1_0_q, rf_1_0_d;
   logic        lcs_n_q, lcs_n_d;
   logic        wcs_n_q, wcs_n_d;
   logic        rwcs_n_q, rwcs_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        active;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      mi_d     = mi_q;
      dir_d    = dir_q;
      mi_out_d = mi_out_q;
      case (state_q)
         S_IDLE: begin
            if (bus.START && !bus.ABORT) begin
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
               word_d  = 2'd0;
               mi_d    = bus.MI_IN;
               dir_d   = bus.DIR;
            end
         end
         S_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = S_STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_HOLD;
               if (dir_q) mi_out_d[{word_q, 4'd0} +: 16] = bus.CS_DATA_IN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            if (word_q == 2'd3) begin
               state_d = S_FIN;
            end else begin
               state_d = S_SETUP;
               cnt_d   = SETUP_LD;
               word_d  = word_q + 2'd1;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort beats everything, including a capture on the final strobe cycle.
      if (bus.ABORT && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         mi_out_d = mi_out_q;
      end
   end

   // Outputs are decoded from the next state so the registered pins line up
   // with the state they describe.
   always_comb begin
      active        = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      lcs_n_d       = !active;
      busy_d        = active;
      done_d        = (state_d == S_FIN);
      wcs_n_d       = !((state_d == S_STROBE) && !dir_d);
      rwcs_n_d      = !((state_d == S_STROBE) && dir_d);
      rf_1_0_d      = rf_1_0_q;
      cs_data_out_d = cs_data_out_q;
      if (active) begin
         rf_1_0_d      = word_d;
         cs_data_out_d = dir_d ? 16'd0 : mi_d[{word_d, 4'd0} +: 16];
      end
   end

   always_ff @(posedge sysclk) begin
      if (!sys_rst_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= 4'd0;
         word_q        <= 2'd0;
         mi_q          <= 64'd0;
         dir_q         <= 1'b0;
         mi_out_q      <= 64'd0;
         cs_data_out_q <= 16'd0;
         rf_1_0_q      <= 2'd0;
         lcs_n_q       <= 1'b1;
         wcs_n_q       <= 1'b1;
         rwcs_n_q      <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         word_q        <= word_d;
         mi_q          <= mi_d;
         dir_q         <= dir_d;
         mi_out_q      <= mi_out_d;
         cs_data_out_q <= cs_data_out_d;
         rf_1_0_q      <= rf_1_0_d;
         lcs_n_q       <= lcs_n_d;
         wcs_n_q       <= wcs_n_d;
         rwcs_n_q      <= rwcs_n_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.CS_DATA_OUT = cs_data_out_q;
   assign bus.MI_OUT      = mi_out_q;
   assign bus.RF_1_0      = rf_1_0_q;
   assign bus.LCS_n       = lcs_n_q;
   assign bus.WCS_n       = wcs_n_q;
   assign bus.RWCS_n      = rwcs_n_q;
   assign bus.BUSY        = busy_q;
   assign bus.DONE        = done_q;

endmodule

// File: doc/cs_wcs_seq.md
Name: cs_wcs_seq

Overview:
- Writable-control-store load/readback sequencer for the CPU board.
- Sits directly upstream of the control-store control decoder: generates RF_1_0 (word select), LCS_n, WCS_n and RWCS_n timing for a 64-bit microinstruction moved as four 16-bit words.
- Drives the 16-bit word to the store on writes; assembles the 64-bit readback on reads.
- The downstream decoder turns these into per-word enable and write strobes.

Parameters:
- SETUP_CYCLES, 1, cycles RF/data/LCS_n are stable before the strobe (1..15).
- STROBE_CYCLES, 2, cycles the write or read strobe is held low (1..15).

Ports:
- sysclk  in  1  system clock; all state changes on rising edge.
- sys_rst_n  in  1  synchronous active-low reset.
- START  in  1  request pulse; sampled only in IDLE.
- DIR  in  1  0 = write microinstruction, 1 = read back; latched with START.
- ABORT  in  1  synchronous cancel.
- MI_IN  in  64  microinstruction to write; latched with START.
- CS_DATA_IN  in  16  word read from the control store.
- CS_DATA_OUT  out  16  word driven to the control store.
- MI_OUT  out  64  assembled readback.
- RF_1_0  out  2  word index to the downstream decoder.
- LCS_n  out  1  load-control-store mode, low for the whole transaction.
- WCS_n  out  1  write strobe, low during STROBE on writes.
- RWCS_n  out  1  read strobe, low during STROBE on reads.
- BUSY  out  1  transaction in progress.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low (sysclk, sys_rst_n).
- All outputs are registered.
- Reset values:
  - LCS_n = WCS_n = RWCS_n = 1.
  - RF_1_0 = 0, BUSY = 0, DONE = 0.
  - CS_DATA_OUT = 0, MI_OUT = 0.
  - Internal mi_reg = 0, dir_reg = 0, state = IDLE.
- Word mapping: word k = bits [16k+15:16k]; RF_1_0 = k; words run 0,1,2,3 in that order.
- States and transitions:
  - IDLE: START=1 and ABORT=0 → latch MI_IN, DIR; word = 0; go to SETUP.
  - SETUP: held for SETUP_CYCLES, then go to STROBE.
  - STROBE: held for STROBE_CYCLES, then go to HOLD.
  - HOLD: 1 cycle. If word = 3, go to FIN; otherwise word+1 and go to SETUP.
  - FIN: 1 cycle, DONE = 1, then go to IDLE.
- Outputs in SETUP, STROBE and HOLD:
  - LCS_n = 0, BUSY = 1, RF_1_0 = word.
  - CS_DATA_OUT = word k of mi_reg when writing; 0 when reading.
- Strobes:
  - STROBE, write: WCS_n = 0.
  - STROBE, read: RWCS_n = 0.
  - The two strobes are never low together and never low outside STROBE.
- Read capture: on the edge that ends the last STROBE cycle, CS_DATA_IN is written into MI_OUT word k; other words are unchanged.
- FIN and IDLE outputs: LCS_n = 1, strobes = 1, BUSY = 0; RF_1_0 and CS_DATA_OUT hold their last values.
- Latency: 1 + 4·(SETUP_CYCLES + STROBE_CYCLES + 1) cycles from the START sample to DONE. With defaults this is 17, i.e. DONE high in cycle N+17.
- Word index wraps never: the transaction ends after word 3.
- START while BUSY or in FIN: ignored, not queued.
- ABORT in any non-IDLE state:
  - Next edge → IDLE; LCS_n, WCS_n, RWCS_n = 1; BUSY = 0; no DONE pulse.
  - MI_OUT keeps only the words already captured.
- ABORT and START together in IDLE: ABORT wins; the sequencer stays in IDLE.
- Reset asserted mid-transaction: all outputs return to reset values on that edge; no DONE pulse.
- A timing counter reloads on every state entry; the parameter value 0 is illegal.

Test Plan:
1. Write, defaults, MI_IN = 0x1111_2222_3333_4444:
   - RF_1_0 sequence 0,1,2,3 with CS_DATA_OUT 0x4444, 0x3333, 0x2222, 0x1111.
   - WCS_n low 2 cycles per word; RWCS_n always 1.
   - LCS_n low 16 cycles; DONE at N+17.
2. Read, CS_DATA_IN = 0xA000 + RF_1_0:
   - MI_OUT = 0xA003_A002_A001_A000 at DONE.
   - RWCS_n low 2 cycles per word; WCS_n always 1.
3. ABORT during the word-2 STROBE of a read:
   - Next cycle: strobes and LCS_n = 1, BUSY = 0, no DONE.
   - MI_OUT words 0–1 updated, words 2–3 unchanged.
4. START pulsed mid-transaction and START+ABORT together in IDLE:
   - Mid-transaction START has no effect; the sequence completes once.
   - The simultaneous START+ABORT case leaves BUSY = 0.
5. sys_rst_n low for 1 cycle during word 1 of a write:
   - All outputs return to reset values at that edge.
   - A subsequent START runs a full 17-cycle transaction.
6. SETUP_CYCLES = 3, STROBE_CYCLES = 4:
   - Each word takes 8 cycles; DONE at N+33.
   - Strobe width is exactly 4 cycles.
